// File: rtl/traffic_ctrl_nphase.sv
// N-phase traffic-light controller: GREEN -> YELLOW -> ALL-RED per phase, demand-based
// phase skipping, prescaled tick timer, test mode and flashing mode.
//
// state  | meaning
// S_GRN  | green on current phase, all other phases red
// S_YLW  | yellow on current phase, all other phases red
// S_RED  | all-red clearance; picks the next phase on exit
// S_FLS  | flashing: phase 0 yellow and other phases red blink together
module traffic_ctrl_nphase #(
    parameter int NPHASE   = 2,
    parameter int TW       = 8,
    parameter int PRESC    = 16,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2
) (
    input  logic                      clock,
    input  logic                      pclr_n,
    input  logic                      ptest,
    input  logic                      pfm,
    input  logic [NPHASE-1:0]         preq,
    output logic [NPHASE-1:0]         pgrn,
    output logic [NPHASE-1:0]         pylw,
    output logic [NPHASE-1:0]         pred,
    output logic [$clog2(NPHASE)-1:0] phase_o,
    output logic                      tick_o
);

    localparam int PW = $clog2(NPHASE);
    localparam int CW = $clog2(PRESC);

    typedef enum logic [1:0] {S_GRN, S_YLW, S_RED, S_FLS} state_t;

    state_t            state, state_d;
    logic [PW-1:0]     phase, phase_d, nxt_phase;
    logic [TW-1:0]     timer, timer_d;
    logic [CW-1:0]     pcnt;
    logic [NPHASE-1:0] pending, clr_mask;
    logic              blink, blink_d;
    logic              adv, adv_d;
    logic              ptest_q, pfm_q;
    logic              tick, enter_grn;
    logic [PW:0]       scan_sum;

    assign tick    = (pcnt == CW'(PRESC - 1)) | ptest_q;
    assign tick_o  = tick;
    assign phase_o = phase;

    // Lowest-distance pending phase wins; descending scan lets the nearest overwrite last.
    always_comb begin
        scan_sum  = {1'b0, phase} + (PW+1)'(1);
        if (scan_sum >= (PW+1)'(NPHASE))
            scan_sum = scan_sum - (PW+1)'(NPHASE);
        nxt_phase = scan_sum[PW-1:0];
        for (int k = NPHASE - 1; k >= 1; k--) begin
            scan_sum = {1'b0, phase} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NPHASE))
                scan_sum = scan_sum - (PW+1)'(NPHASE);
            if (pending[scan_sum[PW-1:0]])
                nxt_phase = scan_sum[PW-1:0];
        end
    end

    always_comb begin
        state_d   = state;
        phase_d   = phase;
        timer_d   = timer;
        blink_d   = blink;
        adv_d     = adv;
        enter_grn = 1'b0;
        if (tick) begin
            case (state)
                S_GRN: begin
                    if (pfm_q || timer == '0) begin
                        state_d = S_YLW;
                        timer_d = TW'(YELLOW_T - 1);
                    end else begin
                        timer_d = timer - 1'b1;
                    end
                end
                S_YLW: begin
                    if (timer == '0) begin
                        if (pfm_q) begin
                            state_d = S_FLS;
                            phase_d = '0;
                        end else begin
                            state_d = S_RED;
                            timer_d = TW'(ALLRED_T - 1);
                            adv_d   = 1'b1;
                        end
                    end else begin
                        timer_d = timer - 1'b1;
                    end
                end
                S_RED: begin
                    if (timer == '0) begin
                        if (pfm_q) begin
                            state_d = S_FLS;
                            phase_d = '0;
                        end else begin
                            // After reset or flashing the current phase is served, not skipped.
                            state_d   = S_GRN;
                            phase_d   = adv ? nxt_phase : phase;
                            timer_d   = TW'(GREEN_T - 1);
                            adv_d     = 1'b0;
                            enter_grn = 1'b1;
                        end
                    end else begin
                        timer_d = timer - 1'b1;
                    end
                end
                S_FLS: begin
                    blink_d = ~blink;
                    if (!pfm_q) begin
                        state_d = S_RED;
                        phase_d = '0;
                        timer_d = TW'(ALLRED_T - 1);
                        adv_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        clr_mask          = '0;
        clr_mask[phase_d] = enter_grn;
    end

    always_ff @(posedge clock) begin
        if (!pclr_n) begin
            state   <= S_RED;
            phase   <= '0;
            timer   <= TW'(ALLRED_T - 1);
            pcnt    <= '0;
            pending <= '0;
            blink   <= 1'b0;
            adv     <= 1'b0;
            ptest_q <= 1'b0;
            pfm_q   <= 1'b0;
        end else begin
            state   <= state_d;
            phase   <= phase_d;
            timer   <= timer_d;
            pcnt    <= (pcnt == CW'(PRESC - 1)) ? '0 : pcnt + 1'b1;
            pending <= (pending & ~clr_mask) | preq;
            blink   <= blink_d;
            adv     <= adv_d;
            ptest_q <= ptest;
            pfm_q   <= pfm;
        end
    end

    always_comb begin
        pgrn = '0;
        pylw = '0;
        pred = '1;
        case (state)
            S_GRN: begin
                pgrn[phase] = 1'b1;
                pred[phase] = 1'b0;
            end
            S_YLW: begin
                pylw[phase] = 1'b1;
                pred[phase] = 1'b0;
            end
            S_RED: ;
            S_FLS: begin
                pred    = {NPHASE{blink}};
                pred[0] = 1'b0;
                pylw[0] = blink;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_nphase.sv
// Scoreboard bench for traffic_ctrl_nphase: expected lamp-change events, tick cycles and
// green order are queued by the stimulus and checked by independent negedge monitors.
module tb_traffic_ctrl_nphase;

    localparam logic [3:0] F = 4'b1111;

    logic       clock = 1'b0;
    logic       pclr_n, ptest, pfm;
    logic [3:0] preq;
    logic [3:0] pgrn, pylw, pred;
    logic [1:0] phase_o;
    logic       tick_o;
    logic [2:0] pgrn3, pylw3, pred3;
    logic [1:0] phase3;
    logic       tick3;

    typedef struct {int cyc; logic [13:0] val;} ev_t;
    typedef struct {int cyc; logic [1:0] ph;} g_t;

    ev_t  exp_q[$];
    int   tick_q[$];
    g_t   g3_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 1000;
    logic started = 1'b0;
    logic chk_tick = 1'b0;
    logic en3 = 1'b0;

    always #5 clock = ~clock;

    traffic_ctrl_nphase #(.NPHASE(4), .TW(8), .PRESC(4), .GREEN_T(3), .YELLOW_T(2), .ALLRED_T(1)) u_dut (
        .clock(clock), .pclr_n(pclr_n), .ptest(ptest), .pfm(pfm), .preq(preq),
        .pgrn(pgrn), .pylw(pylw), .pred(pred), .phase_o(phase_o), .tick_o(tick_o)
    );

    traffic_ctrl_nphase #(.NPHASE(3), .TW(8), .PRESC(4), .GREEN_T(3), .YELLOW_T(2), .ALLRED_T(1)) u_dut3 (
        .clock(clock), .pclr_n(pclr_n), .ptest(ptest), .pfm(1'b0), .preq(3'b000),
        .pgrn(pgrn3), .pylw(pylw3), .pred(pred3), .phase_o(phase3), .tick_o(tick3)
    );

    always @(posedge clock) cyc <= pclr_n ? cyc + 1 : 0;

    // Lamp monitor: any change of outputs, or the first cycle after reset, is an event.
    logic [13:0] prev_v;
    always @(negedge clock) begin
        logic [13:0] cur;
        ev_t e;
        cur = {pgrn, pylw, pred, phase_o};
        if (started && ((cur !== prev_v) || cyc == 0)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL lamp_event: unexpected change at cyc=%0d val=%h", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || cur !== e.val) begin
                    n_err++;
                    $display("FAIL lamp_event: got cyc=%0d g/y/r/ph=%h, expected cyc=%0d g/y/r/ph=%h",
                             cyc, cur, e.cyc, e.val);
                end
            end
        end
        prev_v = cur;
    end

    always @(negedge clock) begin
        int t;
        if (chk_tick && tick_o) begin
            n_chk++;
            if (tick_q.size() == 0) begin
                n_err++;
                $display("FAIL tick: unexpected tick at cyc=%0d", cyc);
            end else begin
                t = tick_q.pop_front();
                if (t != cyc) begin
                    n_err++;
                    $display("FAIL tick: got cyc=%0d, expected cyc=%0d", cyc, t);
                end
            end
        end
    end

    logic [2:0] prev_g3;
    always @(negedge clock) begin
        g_t  g;
        logic bad;
        if (en3) begin
            bad = 1'b0;
            for (int k = 0; k < 3; k++)
                if (int'(pgrn3[k]) + int'(pylw3[k]) + int'(pred3[k]) != 1) bad = 1'b1;
            n_chk++;
            if (bad) begin
                n_err++;
                $display("FAIL lamp_excl3: cyc=%0d g=%b y=%b r=%b, expected one lamp per phase",
                         cyc, pgrn3, pylw3, pred3);
            end
            if (pgrn3 !== prev_g3 && pgrn3 != 3'b000) begin
                n_chk++;
                if (g3_q.size() == 0) begin
                    n_err++;
                    $display("FAIL green3: unexpected green %b at cyc=%0d", pgrn3, cyc);
                end else begin
                    g = g3_q.pop_front();
                    if (cyc != g.cyc || phase3 != g.ph || pgrn3 != (3'b001 << g.ph)) begin
                        n_err++;
                        $display("FAIL green3: got cyc=%0d ph=%0d g=%b, expected cyc=%0d ph=%0d",
                                 cyc, phase3, pgrn3, g.cyc, g.ph);
                    end
                end
            end
        end
        prev_g3 = pgrn3;
    end

    task automatic ev(input int c, input logic [3:0] g, input logic [3:0] y,
                      input logic [3:0] r, input logic [1:0] ph);
        exp_q.push_back('{c, {g, y, r, ph}});
    endtask

    task automatic run_to(input int c);
        int guard = 0;
        while (cyc != c) begin
            @(posedge clock); #1;
            guard++;
            if (guard > 500) begin
                n_chk++; n_err++;
                $display("FAIL run_to: cycle %0d not reached, at %0d", c, cyc);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1 pclr_n = 1'b0;
        @(posedge clock); #1 pclr_n = 1'b1;
    endtask

    task automatic drain(input string name);
        @(negedge clock); #1;
        n_chk++;
        if (exp_q.size() != 0 || tick_q.size() != 0 || g3_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: left ev=%0d tick=%0d green3=%0d, expected 0 0 0",
                     name, exp_q.size(), tick_q.size(), g3_q.size());
            exp_q.delete(); tick_q.delete(); g3_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "timeout");
    end

    initial begin
        pclr_n = 1'b0; ptest = 1'b0; pfm = 1'b0; preq = 4'b0000;

        // T1: prescaled timing from reset
        ev(0, 0, 0, F, 0); ev(4, 1, 0, 4'b1110, 0); ev(16, 0, 1, 4'b1110, 0);
        ev(24, 0, 0, F, 0); ev(28, 2, 0, 4'b1101, 1);
        for (int t = 3; t <= 27; t += 4) tick_q.push_back(t);
        @(posedge clock); #1 pclr_n = 1'b1;
        started = 1'b1; chk_tick = 1'b1;
        run_to(30);
        drain("t1");
        chk_tick = 1'b0;

        // T2: test mode, one tick per cycle, rotation 0 -> 1 -> 2
        ptest = 1'b1;
        ev(0, 0, 0, F, 0); ev(2, 1, 0, 4'b1110, 0); ev(5, 0, 1, 4'b1110, 0);
        ev(7, 0, 0, F, 0); ev(8, 2, 0, 4'b1101, 1); ev(11, 0, 2, 4'b1101, 1);
        ev(13, 0, 0, F, 1); ev(14, 4, 0, 4'b1011, 2);
        do_reset();
        run_to(15);
        drain("t2");

        // T3: demand on phase 3 skips 1 and 2; bit clears so phase 1 follows phase 0
        ev(0, 0, 0, F, 0); ev(2, 1, 0, 4'b1110, 0); ev(5, 0, 1, 4'b1110, 0);
        ev(7, 0, 0, F, 0); ev(8, 8, 0, 4'b0111, 3); ev(11, 0, 8, 4'b0111, 3);
        ev(13, 0, 0, F, 3); ev(14, 1, 0, 4'b1110, 0); ev(17, 0, 1, 4'b1110, 0);
        ev(19, 0, 0, F, 0); ev(20, 2, 0, 4'b1101, 1);
        do_reset();
        run_to(3); preq = 4'b1000;
        run_to(4); preq = 4'b0000;
        run_to(21);
        drain("t3");

        // T4: flashing mode entered from green, left through one all-red tick
        ev(0, 0, 0, F, 0); ev(2, 1, 0, 4'b1110, 0); ev(4, 0, 1, 4'b1110, 0);
        ev(6, 0, 0, 0, 0); ev(7, 0, 1, 4'b1110, 0); ev(8, 0, 0, 0, 0);
        ev(9, 0, 1, 4'b1110, 0); ev(10, 0, 0, 0, 0); ev(11, 0, 0, F, 0);
        ev(12, 1, 0, 4'b1110, 0);
        do_reset();
        run_to(2); pfm = 1'b1;
        run_to(9); pfm = 1'b0;
        run_to(13);
        drain("t4");

        // T5: reset pulse during yellow restarts the T1 sequence
        ptest = 1'b0;
        ev(0, 0, 0, F, 0); ev(4, 1, 0, 4'b1110, 0); ev(16, 0, 1, 4'b1110, 0);
        ev(0, 0, 0, F, 0); ev(4, 1, 0, 4'b1110, 0); ev(16, 0, 1, 4'b1110, 0);
        ev(24, 0, 0, F, 0); ev(28, 2, 0, 4'b1101, 1);
        do_reset();
        run_to(17);
        do_reset();
        chk_tick = 1'b1;
        for (int t = 3; t <= 27; t += 4) tick_q.push_back(t);
        run_to(29);
        drain("t5");
        chk_tick = 1'b0;

        // T6: full wrap on 4 phases and on 3 phases
        ptest = 1'b1;
        ev(0, 0, 0, F, 0); ev(2, 1, 0, 4'b1110, 0); ev(5, 0, 1, 4'b1110, 0);
        ev(7, 0, 0, F, 0); ev(8, 2, 0, 4'b1101, 1); ev(11, 0, 2, 4'b1101, 1);
        ev(13, 0, 0, F, 1); ev(14, 4, 0, 4'b1011, 2); ev(17, 0, 4, 4'b1011, 2);
        ev(19, 0, 0, F, 2); ev(20, 8, 0, 4'b0111, 3); ev(23, 0, 8, 4'b0111, 3);
        ev(25, 0, 0, F, 3); ev(26, 1, 0, 4'b1110, 0);
        g3_q.push_back('{2, 2'd0}); g3_q.push_back('{8, 2'd1}); g3_q.push_back('{14, 2'd2});
        g3_q.push_back('{20, 2'd0}); g3_q.push_back('{26, 2'd1});
        do_reset();
        en3 = 1'b1;
        run_to(27);
        drain("t6");
        en3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
